// File: rtl/halut_result_collector.sv
// Result collector behind the multi-decoder array: buffers the non-stallable FP32 row stream
// in a FIFO, re-emits it on valid/ready, checks row ordering and counts completed groups.
module halut_result_collector #(
    parameter int unsigned DecoderUnits = 16,
    parameter int unsigned FifoDepth    = 32,
    parameter int unsigned DecAddrWidth = $clog2(DecoderUnits),
    parameter int unsigned PtrWidth     = $clog2(FifoDepth)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    input  logic [DecAddrWidth-1:0] m_addr_i,
    input  logic [31:0]             result_i,
    input  logic                    clear_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [31:0]             out_data_o,
    output logic [DecAddrWidth-1:0] out_m_addr_o,
    output logic                    out_last_o,
    output logic [PtrWidth:0]       fill_o,
    output logic [15:0]             groups_o,
    output logic                    overflow_o,
    output logic                    seq_err_o
);

    localparam logic [PtrWidth:0]       FULL_CNT = (PtrWidth+1)'(FifoDepth);
    localparam logic [PtrWidth:0]       ZERO_CNT = (PtrWidth+1)'(0);
    localparam logic [PtrWidth:0]       CNT_ONE  = (PtrWidth+1)'(1);
    localparam logic [PtrWidth-1:0]     PTR_ONE  = PtrWidth'(1);
    localparam logic [PtrWidth-1:0]     PTR_ZERO = PtrWidth'(0);
    localparam logic [DecAddrWidth-1:0] LAST_ROW = DecAddrWidth'(DecoderUnits - 1);
    localparam logic [DecAddrWidth-1:0] ADDR_ONE = DecAddrWidth'(1);
    localparam logic [DecAddrWidth-1:0] ADDR_ZERO = DecAddrWidth'(0);

    logic [31:0]             data_mem_r [FifoDepth];
    logic [DecAddrWidth-1:0] addr_mem_r [FifoDepth];

    logic [PtrWidth-1:0]     wr_ptr_r;
    logic [PtrWidth-1:0]     rd_ptr_r;
    logic [PtrWidth:0]       cnt_r;
    logic [DecAddrWidth-1:0] exp_r;
    logic [15:0]             groups_r;
    logic                    overflow_r;
    logic                    seq_err_r;

    logic full_s;
    logic pop_s;
    logic push_s;
    logic drop_s;
    logic last_in_s;
    logic mismatch_s;

    // Handshake decode; a full FIFO still accepts when the head retires in the same cycle
    always_comb begin
        full_s     = (cnt_r == FULL_CNT);
        pop_s      = (cnt_r != ZERO_CNT) & out_ready_i;
        push_s     = valid_i & (~full_s | pop_s);
        drop_s     = valid_i & full_s & ~pop_s;
        last_in_s  = (m_addr_i == LAST_ROW);
        mismatch_s = valid_i & (m_addr_i != exp_r);
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            cnt_r    <= ZERO_CNT;
        end else if (clear_i) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            cnt_r    <= ZERO_CNT;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_ONE;
                2'b01:   cnt_r <= cnt_r - CNT_ONE;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk_i) begin
        if (push_s && !clear_i) begin
            data_mem_r[wr_ptr_r] <= result_i;
            addr_mem_r[wr_ptr_r] <= m_addr_i;
        end
    end

    // Sequence checker, group counter and sticky flags; dropped beats still resync the checker
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            exp_r      <= ADDR_ZERO;
            groups_r   <= 16'd0;
            overflow_r <= 1'b0;
            seq_err_r  <= 1'b0;
        end else if (clear_i) begin
            exp_r      <= ADDR_ZERO;
            groups_r   <= 16'd0;
            overflow_r <= 1'b0;
            seq_err_r  <= 1'b0;
        end else begin
            if (valid_i) begin
                exp_r <= m_addr_i + ADDR_ONE;
            end
            if (mismatch_s) begin
                seq_err_r <= 1'b1;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if (push_s && last_in_s) begin
                groups_r <= groups_r + 16'd1;
            end
        end
    end

    assign out_valid_o  = (cnt_r != ZERO_CNT);
    assign out_data_o   = data_mem_r[rd_ptr_r];
    assign out_m_addr_o = addr_mem_r[rd_ptr_r];
    assign out_last_o   = out_valid_o & (addr_mem_r[rd_ptr_r] == LAST_ROW);
    assign fill_o       = cnt_r;
    assign groups_o     = groups_r;
    assign overflow_o   = overflow_r;
    assign seq_err_o    = seq_err_r;

endmodule
